// File: rtl/pbit_bias_lut_pipe.sv
// Pipelined p-bit activation: |I| scaled by a beta shift indexes a loadable threshold
// table, and the threshold is compared against an RNG word with sign symmetry.
module pbit_bias_lut_pipe #(
    parameter int I_BIT_WIDTH   = 6,
    parameter int RNG_BIT_WIDTH = 32,
    parameter int LUT_DEPTH     = 2 ** (I_BIT_WIDTH - 1),
    parameter int BETA_W        = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [I_BIT_WIDTH-1:0]   i_in,
    input  logic [RNG_BIT_WIDTH-1:0] rng_in,
    input  logic [BETA_W-1:0]        beta_shift,
    input  logic                     lut_we,
    input  logic [I_BIT_WIDTH-2:0]   lut_addr,
    input  logic [RNG_BIT_WIDTH-1:0] lut_wdata,
    output logic                     out_valid,
    output logic                     spin_out
);

    localparam int IDX_W  = I_BIT_WIDTH - 1;
    localparam int SHMAX  = (2 ** BETA_W) - 1;
    localparam int WIDE_W = IDX_W + SHMAX;
    localparam logic [RNG_BIT_WIDTH-1:0] MID_C  = {1'b1, {(RNG_BIT_WIDTH-1){1'b0}}};
    localparam logic [RNG_BIT_WIDTH-1:0] ONES_C = {RNG_BIT_WIDTH{1'b1}};
    localparam logic [I_BIT_WIDTH-1:0]   ONE_C  = {{(I_BIT_WIDTH-1){1'b0}}, 1'b1};

    logic [RNG_BIT_WIDTH-1:0] lut_r [LUT_DEPTH];

    logic [I_BIT_WIDTH-1:0]   neg_s;
    logic [IDX_W-1:0]         mag_s;
    logic [WIDE_W-1:0]        wide_s;
    logic [IDX_W-1:0]         idx_s;

    logic                     s0_valid_r;
    logic                     s0_sign_r;
    logic [IDX_W-1:0]         s0_idx_r;
    logic [RNG_BIT_WIDTH-1:0] s0_rng_r;

    logic                     s1_valid_r;
    logic                     s1_sign_r;
    logic [RNG_BIT_WIDTH-1:0] s1_rng_r;
    logic [RNG_BIT_WIDTH-1:0] s1_thr_r;

    // Magnitude, beta scaling and clamp to the last table entry
    always_comb begin
        neg_s  = (~i_in) + ONE_C;
        mag_s  = {IDX_W{1'b0}};
        wide_s = {WIDE_W{1'b0}};
        idx_s  = {IDX_W{1'b0}};
        if (i_in[I_BIT_WIDTH-1]) begin
            // Negating the most negative code wraps back to itself, so clamp it
            if (neg_s[I_BIT_WIDTH-1]) begin
                mag_s = {IDX_W{1'b1}};
            end else begin
                mag_s = neg_s[IDX_W-1:0];
            end
        end else begin
            mag_s = i_in[IDX_W-1:0];
        end
        wide_s = {{SHMAX{1'b0}}, mag_s} << beta_shift;
        if (|wide_s[WIDE_W-1:IDX_W]) begin
            idx_s = {IDX_W{1'b1}};
        end else begin
            idx_s = wide_s[IDX_W-1:0];
        end
    end

    // Threshold table: defaults on reset, otherwise single-port write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LUT_DEPTH; k++) begin
                lut_r[k] <= ONES_C;
            end
            lut_r[0] <= MID_C;
        end else if (lut_we) begin
            lut_r[lut_addr] <= lut_wdata;
        end
    end

    // Stage 0: capture sign, clamped index and RNG word
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_r <= 1'b0;
            s0_sign_r  <= 1'b0;
            s0_idx_r   <= {IDX_W{1'b0}};
            s0_rng_r   <= {RNG_BIT_WIDTH{1'b0}};
        end else begin
            s0_valid_r <= in_valid;
            if (in_valid) begin
                s0_sign_r <= i_in[I_BIT_WIDTH-1];
                s0_idx_r  <= idx_s;
                s0_rng_r  <= rng_in;
            end
        end
    end

    // Stage 1: table read sees the pre-write value on a same-cycle collision
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_sign_r  <= 1'b0;
            s1_rng_r   <= {RNG_BIT_WIDTH{1'b0}};
            s1_thr_r   <= {RNG_BIT_WIDTH{1'b0}};
        end else begin
            s1_valid_r <= s0_valid_r;
            s1_sign_r  <= s0_sign_r;
            s1_rng_r   <= s0_rng_r;
            s1_thr_r   <= lut_r[s0_idx_r];
        end
    end

    // Stage 2: sign-symmetric compare; spin holds while no result is valid
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            spin_out  <= 1'b0;
        end else begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                if (s1_sign_r) begin
                    spin_out <= (s1_rng_r >= s1_thr_r);
                end else begin
                    spin_out <= (s1_rng_r < s1_thr_r);
                end
            end
        end
    end

endmodule

// File: tb/tb_pbit_bias_lut_pipe.sv
// Directed and randomized bench for pbit_bias_lut_pipe, checked against a
// transaction-level threshold model with a two-cycle result queue.
module tb_pbit_bias_lut_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [5:0]  i_in = 6'd0;
    logic [31:0] rng_in = 32'd0;
    logic [1:0]  beta_shift = 2'd0;
    logic        lut_we = 1'b0;
    logic [4:0]  lut_addr = 5'd0;
    logic [31:0] lut_wdata = 32'd0;
    logic        out_valid;
    logic        spin_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mlut [32];
    logic        exp_valid = 1'b0, exp_spin = 1'b0;
    logic        res_valid = 1'b0, res_spin = 1'b0;
    logic        pend_valid = 1'b0;
    logic [5:0]  pend_i;
    logic [31:0] pend_r;
    logic [1:0]  pend_b;

    pbit_bias_lut_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .i_in(i_in), .rng_in(rng_in),
        .beta_shift(beta_shift), .lut_we(lut_we), .lut_addr(lut_addr),
        .lut_wdata(lut_wdata), .out_valid(out_valid), .spin_out(spin_out)
    );

    always #5 clk = ~clk;

    function automatic logic model_spin(input logic [5:0] i, input logic [31:0] r,
                                        input logic [1:0] b);
        int v, m, idx;
        logic [31:0] thr;
        v = $signed(i);
        m = (v < 0) ? -v : v;
        if (m > 31) m = 31;
        idx = m * (2 ** b);
        if (idx > 31) idx = 31;
        thr = mlut[idx];
        return (v < 0) ? (r >= thr) : (r < thr);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 32; k++) mlut[k] = 32'hFFFF_FFFF;
        mlut[0] = 32'h8000_0000;
    endtask

    // One clock: advance the model from the inputs seen at the edge, then compare.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            exp_valid = 1'b0; exp_spin = 1'b0; res_valid = 1'b0; pend_valid = 1'b0;
            model_reset();
        end else begin
            exp_valid = res_valid;
            if (res_valid) exp_spin = res_spin;
            res_valid = pend_valid;
            if (pend_valid) res_spin = model_spin(pend_i, pend_r, pend_b);
            if (lut_we) mlut[lut_addr] = lut_wdata;
            pend_valid = in_valid; pend_i = i_in; pend_r = rng_in; pend_b = beta_shift;
        end
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
        chk("spin_out",  {31'd0, spin_out},  {31'd0, exp_spin});
        in_valid = 1'b0; lut_we = 1'b0; rst = 1'b0; beta_shift = 2'd0;
    endtask

    task automatic put(input logic [5:0] i, input logic [31:0] r, input logic [1:0] b);
        in_valid = 1'b1; i_in = i; rng_in = r; beta_shift = b;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        lut_we = 1'b1; lut_addr = a; lut_wdata = d;
    endtask

    task automatic one(input string tag, input logic [5:0] i, input logic [31:0] r,
                       input logic [1:0] b, input logic expv);
        put(i, r, b); tick(); tick(); tick();
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk(tag, {31'd0, spin_out}, {31'd0, expv});
    endtask

    initial begin
        model_reset();
        tick(); tick();
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_spin",  {31'd0, spin_out},  32'd0);

        // Midpoint entry after reset
        one("mid_lo", 6'd0, 32'h7FFF_FFFF, 2'd0, 1'b1);
        one("mid_hi", 6'd0, 32'h8000_0000, 2'd0, 1'b0);

        // Programmed entry and sign symmetry
        wr(5'd5, 32'h4000_0000); tick();
        one("pos5_below", 6'd5,        32'h3FFF_FFFF, 2'd0, 1'b1);
        one("pos5_equal", 6'd5,        32'h4000_0000, 2'd0, 1'b0);
        one("neg5_equal", 6'b111011,   32'h4000_0000, 2'd0, 1'b1);
        one("neg5_below", 6'b111011,   32'h3FFF_FFFF, 2'd0, 1'b0);

        // Saturation and beta scaling
        one("neg32_sat", 6'b100000, 32'd0, 2'd0, 1'b0);
        wr(5'd16, 32'h0000_0010); tick();
        one("beta_idx16", 6'd4, 32'h0000_000F, 2'd2, 1'b1);
        one("beta_clamp", 6'd9, 32'd0, 2'd2, 1'b1);

        // Collision: write lands in the same cycle as the stage 1 read
        wr(5'd7, 32'h8000_0000); tick();
        put(6'd7, 32'h10, 2'd0); tick();
        wr(5'd7, 32'h0); tick(); tick();
        chk("coll_old", {31'd0, spin_out}, 32'd1);
        one("coll_new", 6'd7, 32'h10, 2'd0, 1'b0);

        // Throughput: 10 back-to-back, 3-cycle gap, 2 more
        for (int k = 0; k < 15; k++) begin
            if (k < 10 || k >= 13) put(6'($urandom), $urandom, 2'($urandom));
            tick();
        end
        tick(); tick();

        // Random traffic with interleaved table writes
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) != 0) begin
                logic [31:0] r;
                r = $urandom;
                if ($urandom_range(0, 3) == 0) r = mlut[$urandom_range(0, 31)] - 32'($urandom_range(0, 1));
                put(6'($urandom), r, 2'($urandom));
            end
            if ($urandom_range(0, 4) == 0) wr(5'($urandom), $urandom);
            tick();
        end
        tick(); tick();

        // Reset mid-flight, with a simultaneous write that must be discarded
        wr(5'd5, 32'h4000_0000); tick();
        put(6'd1, 32'd0, 2'd0); tick();
        put(6'd2, 32'd0, 2'd0); tick();
        rst = 1'b1; wr(5'd0, 32'd0); tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_spin",  {31'd0, spin_out},  32'd0);
        tick(); tick();
        chk("rst_drop", {31'd0, out_valid}, 32'd0);
        one("rst_entry5", 6'b111011, 32'hFFFF_FFFE, 2'd0, 1'b0);
        one("rst_entry0", 6'd0, 32'h7FFF_FFFF, 2'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
